lbp_host_mem: RTL and testbench

Host-side responder for the LBP image interface. It holds the 128×128 gray image and serves `gray_data` for each `gray_addr` the LBP engine requests. It captures every `lbp_valid` write into a result memory and checks write completeness and uniqueness up to `finish`. It sits opposite the LBP engine on the gray/lbp bus and is the block the engine is simulated and emulated against.

---
 rtl/lbp_pkg.sv | 17 +
 rtl/lbp_img_ram.sv | 33 +++
 rtl/lbp_host_mem.sv | 130 +++++++++++++
 tb/tb_lbp_host_mem.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared constants and state type for the LBP host responder and engine benches.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lbp_pkg;

  localparam int IMG_W      = 128;
  localparam int ADDR_W     = 14;
  localparam int PIX_W      = 8;
  localparam int IMG_PIXELS = IMG_W * IMG_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } host_state_t;

endpackage

// File: rtl/lbp_img_ram.sv
// Image-sized RAM: one synchronous write port, one registered read port.
// Latency: read data valid one cycle after a read-enabled edge; holds otherwise.
// Backpressure: none, a read and a write may be issued every cycle.
module lbp_img_ram
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [IMG_PIXELS];

  // Storage array is never reset so image contents survive a session reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register: reset to zero, updated only when a read is enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lbp_host_mem.sv
// Host responder for the LBP engine: serves gray pixels, captures and audits result writes.
// Latency: gray_data and rd_data one cycle after address; result flags update at the write edge.
// Backpressure: none, gray requests and result writes are accepted every cycle in SERVE.
module lbp_host_mem
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [PIX_W-1:0]  load_data,
  input  logic              start,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [PIX_W-1:0]  gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [PIX_W-1:0]  lbp_data,
  input  logic              finish,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic              err_dup,
  output logic              err_incomplete,
  output logic              err_stray,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(IMG_PIXELS);

  host_state_t            state;
  logic [IMG_PIXELS-1:0]  written;

  logic                   in_serve;
  logic                   lbp_wr;
  logic                   is_dup;
  logic                   new_wr;
  logic [ADDR_W:0]        cnt_next;

  // Decode which result writes land and what the counter becomes this cycle.
  always_comb begin
    in_serve = (state == SERVE);
    lbp_wr   = in_serve && lbp_valid;
    is_dup   = written[lbp_addr];
    new_wr   = lbp_wr && !is_dup;
    cnt_next = wr_count;
    if (new_wr && (wr_count != FULL_CNT)) cnt_next = wr_count + 1'b1;
  end

  // Session FSM with registered status outputs, written bitmap and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      gray_ready     <= 1'b0;
      done           <= 1'b0;
      wr_count       <= '0;
      err_dup        <= 1'b0;
      err_incomplete <= 1'b0;
      err_stray      <= 1'b0;
      written        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gray_req || lbp_valid) err_stray <= 1'b1;
          // A start coinciding with a preload write is treated as part of the load.
          if (start && !load_en) begin
            state      <= SERVE;
            gray_ready <= 1'b1;
          end
        end
        SERVE: begin
          if (lbp_wr) begin
            written[lbp_addr] <= 1'b1;
            if (is_dup) err_dup <= 1'b1;
          end
          wr_count <= cnt_next;
          // Completeness includes a write accepted alongside finish.
          if (finish) begin
            state      <= DONE;
            gray_ready <= 1'b0;
            done       <= 1'b1;
            if (cnt_next < FULL_CNT) err_incomplete <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state          <= IDLE;
            done           <= 1'b0;
            wr_count       <= '0;
            err_dup        <= 1'b0;
            err_incomplete <= 1'b0;
            err_stray      <= 1'b0;
            written        <= '0;
          end else if (gray_req || lbp_valid) begin
            err_stray <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          gray_ready <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

  lbp_img_ram u_gray_ram (
    .clk   (clk),
    .reset (reset),
    .we    (load_en && (state == IDLE)),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (in_serve && gray_req),
    .raddr (gray_addr),
    .rdata (gray_data)
  );

  lbp_img_ram u_lbp_ram (
    .clk   (clk),
    .reset (reset),
    .we    (lbp_wr),
    .waddr (lbp_addr),
    .wdata (lbp_data),
    .re    (1'b1),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_lbp_host_mem.sv
// Bench for lbp_host_mem: table-driven reads/readbacks through a scoreboard queue,
// plus hand sequences for session completion, duplicates, stray accesses and reset.
module tb_lbp_host_mem;
  import lbp_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [PIX_W-1:0]  load_data;
  logic              start;
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [PIX_W-1:0]  gray_data;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [PIX_W-1:0]  lbp_data;
  logic              finish;
  logic              done;
  logic [ADDR_W:0]   wr_count;
  logic              err_dup;
  logic              err_incomplete;
  logic              err_stray;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;

  always #5 clk = ~clk;

  lbp_host_mem dut (
    .clk            (clk),
    .reset          (reset),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .start          (start),
    .gray_ready     (gray_ready),
    .gray_req       (gray_req),
    .gray_addr      (gray_addr),
    .gray_data      (gray_data),
    .lbp_valid      (lbp_valid),
    .lbp_addr       (lbp_addr),
    .lbp_data       (lbp_data),
    .finish         (finish),
    .done           (done),
    .wr_count       (wr_count),
    .err_dup        (err_dup),
    .err_incomplete (err_incomplete),
    .err_stray      (err_stray),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  exp;
  } vec_t;

  vec_t             rd_vecs [4];
  vec_t             rb_vecs [3];
  logic [PIX_W-1:0] exp_q [$];
  logic [PIX_W-1:0] last_exp;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic lbp_write(input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] d, input logic fin);
    lbp_valid = 1'b1;
    lbp_addr  = a;
    lbp_data  = d;
    finish    = fin;
    tick();
    lbp_valid = 1'b0;
    finish    = 1'b0;
  endtask

  task automatic gray_read(input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] exp, input string name);
    gray_req  = 1'b1;
    gray_addr = a;
    exp_q.push_back(exp);
    tick();
    gray_req = 1'b0;
    if (exp_q.size() == 0) check({name, "_sb_empty"}, 32'd0, 32'd1);
    else check(name, gray_data, exp_q.pop_front());
  endtask

  initial begin
    rd_vecs[0] = '{addr: 14'h0000, exp: 8'h00};
    rd_vecs[1] = '{addr: 14'h0081, exp: 8'h81};
    rd_vecs[2] = '{addr: 14'h3FFF, exp: 8'hFF};
    rd_vecs[3] = '{addr: 14'h1234, exp: 8'h34};
    rb_vecs[0] = '{addr: 14'h0102, exp: 8'h58};
    rb_vecs[1] = '{addr: 14'h0000, exp: 8'h5A};
    rb_vecs[2] = '{addr: 14'h3FFF, exp: 8'hA5};

    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
    gray_req = 1'b0; gray_addr = '0; lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0;
    finish = 1'b0; rd_addr = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_gray_ready", gray_ready, 0);
    check("rst_gray_data", gray_data, 0);
    check("rst_done", done, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_errs", {err_dup, err_incomplete, err_stray}, 0);
    check("rst_rd_data", rd_data, 0);
    tick();
    #3 reset = 1'b1;

    // Preload image; start on the final load cycle must not leave IDLE.
    for (int k = 0; k < IMG_PIXELS; k++) begin
      load_en   = 1'b1;
      load_addr = k[ADDR_W-1:0];
      load_data = k[PIX_W-1:0];
      start     = (k == IMG_PIXELS - 1);
      tick();
    end
    load_en = 1'b0;
    start   = 1'b0;
    check("start_with_load_stays_idle", gray_ready, 0);

    pulse_start();
    check("gray_ready_serve", gray_ready, 1);

    // Back-to-back reads, one cycle latency each.
    gray_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gray_addr = rd_vecs[i].addr;
      exp_q.push_back(rd_vecs[i].exp);
      last_exp = rd_vecs[i].exp;
      tick();
      if (exp_q.size() == 0) check("gray_sb_empty", 32'd0, 32'd1);
      else check($sformatf("gray_read_%0d", i), gray_data, exp_q.pop_front());
    end
    gray_req = 1'b0;
    tick();
    check("gray_data_hold", gray_data, last_exp);
    check("gray_ready_during_reads", gray_ready, 1);

    // Full result write, finish on the last write.
    for (int a = 0; a < IMG_PIXELS; a++) begin
      lbp_write(a[ADDR_W-1:0], a[PIX_W-1:0] ^ 8'h5A, a == IMG_PIXELS - 1);
    end
    check("full_wr_count", wr_count, IMG_PIXELS);
    check("full_done", done, 1);
    check("full_gray_ready_low", gray_ready, 0);
    check("full_no_errs", {err_dup, err_incomplete, err_stray}, 0);
    for (int i = 0; i < 3; i++) begin
      rd_addr = rb_vecs[i].addr;
      exp_q.push_back(rb_vecs[i].exp);
      tick();
      if (exp_q.size() == 0) check("rb_sb_empty", 32'd0, 32'd1);
      else check($sformatf("readback_%0d", i), rd_data, exp_q.pop_front());
    end

    // Re-arm: DONE -> IDLE clears counters, then a new session.
    pulse_start();
    check("rearm_done_low", done, 0);
    check("rearm_wr_count", wr_count, 0);
    pulse_start();
    check("rearm_serve", gray_ready, 1);

    // Duplicate write to 0x0005, then an incomplete finish at 100 writes.
    lbp_write(14'h0005, 8'h11, 1'b0);
    check("dup_first_count", wr_count, 1);
    check("dup_first_flag", err_dup, 0);
    lbp_write(14'h0005, 8'h22, 1'b0);
    check("dup_second_count", wr_count, 1);
    check("dup_second_flag", err_dup, 1);
    pulse_start();
    check("start_in_serve_ignored", {gray_ready, done}, 2'b10);
    for (int i = 0; i < 99; i++) begin
      lbp_write(14'h2000 + 14'(i), 8'(i), i == 98);
    end
    check("incomplete_flag", err_incomplete, 1);
    check("incomplete_done", done, 1);
    check("incomplete_count", wr_count, 100);
    rd_addr = 14'h0005;
    tick();
    check("dup_readback", rd_data, 8'h22);

    pulse_start();
    check("clear_errs", {err_dup, err_incomplete, err_stray}, 0);

    // Stray write in IDLE, preload attempt during SERVE.
    lbp_write(14'h0102, 8'hEE, 1'b0);
    check("stray_idle", err_stray, 1);
    pulse_start();
    load_en   = 1'b1;
    load_addr = 14'h0081;
    load_data = 8'h00;
    tick();
    load_en = 1'b0;
    gray_read(14'h0081, 8'h81, "load_in_serve_ignored");
    rd_addr = 14'h0102;
    tick();
    check("stray_not_stored", rd_data, 8'h58);
    check("stray_sticky", err_stray, 1);

    // Reset in the middle of a session.
    for (int i = 0; i < 50; i++) begin
      lbp_write(14'h3000 + 14'(i), 8'h40 + 8'(i), 1'b0);
    end
    check("pre_reset_count", wr_count, 50);
    #2 reset = 1'b0;
    #1;
    check("midrst_gray_ready", gray_ready, 0);
    check("midrst_wr_count", wr_count, 0);
    check("midrst_errs", {err_dup, err_incomplete, err_stray, done}, 0);
    #3 reset = 1'b1;
    tick();
    check("post_reset_idle", gray_ready, 0);
    rd_addr = 14'h3000;
    tick();
    check("lbp_mem_retained", rd_data, 8'h40);
    pulse_start();
    check("restart_serve", gray_ready, 1);
    gray_read(14'h3FFF, 8'hFF, "restart_read_3fff");
    gray_read(14'h0081, 8'h81, "restart_read_0081");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
